ppu_vbuf_writer: RTL

//  Upstream neighbour of the LCD video-out stage: takes the PPU's real-time 256x240 pixel stream
//  (7-bit HSV colour per pixel) and writes it into the double-buffered video RAM at the
//  17-bit address {page, y[7:0], x[7:0]}, data 8 bits.

---
 rtl/ppu_vbuf_writer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ppu_vbuf_writer.sv
// ppu_vbuf_writer: turns the PPU pixel stream into video-RAM writes at
// {page, y, x}. Pixels are buffered in a small FIFO because the vbuf write
// port can stall. The write page flips after each complete frame.
// Optional build macro VBUF_WR_OVERSCAN_EN: pixels on the top 8 and bottom
// 8 lines are written black (hsv = 0). Addresses and ordering are unchanged.
module ppu_vbuf_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_PIX      = 256,
  parameter int V_LINES    = 240
) (
  input  logic        i_ppu_clk,
  input  logic        i_ppu_rst,
  input  logic        i_pix_vld,
  input  logic        i_pix_sof,
  input  logic [6:0]  i_pix_hsv,
  output logic        o_pix_rdy,
  output logic        o_vbuf_we,
  output logic [16:0] o_vbuf_addr,
  output logic [7:0]  o_vbuf_wdata,
  input  logic        i_vbuf_wrdy,
  output logic        o_wr_page,
  output logic        o_frame_done,
  output logic        o_ovf,
  output logic        o_sync_err
);

  localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW       = AW + 1;
  localparam logic [7:0]      X_LAST   = 8'(H_PIX - 1);
  localparam logic [7:0]      Y_LAST   = 8'(V_LINES - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic       page;
    logic [7:0] y;
    logic [7:0] x;
    logic [6:0] hsv;
    logic       last;
  } pix_t;

`ifdef VBUF_WR_OVERSCAN_EN
  localparam logic [7:0] Y_BOT = 8'(V_LINES - 8);

  function automatic logic [6:0] blank_hsv(input logic [7:0] y, input logic [6:0] hsv);
    if (y < 8'd8 || y >= Y_BOT) return 7'h00;
    return hsv;
  endfunction
`endif

  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          page_q, page_d;
  logic          sync_err_q, sync_err_d;
  logic          ovf_q, frame_done_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  pix_t          mem_q [FIFO_DEPTH];

  logic [7:0]    pix_x, pix_y;
  logic          pix_last;
  logic [6:0]    pix_hsv;
  pix_t          pix_in, head;
  logic          full, empty, push, pop;

  // "full" is the occupancy at cycle start, so a same-cycle pop never rescues a pixel.
  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = i_pix_vld & ~full;
  assign pop   = ~empty & i_vbuf_wrdy;
  assign head  = mem_q[rd_ptr_q];

`ifdef VBUF_WR_OVERSCAN_EN
  assign pix_hsv = blank_hsv(pix_y, i_pix_hsv);
`else
  assign pix_hsv = i_pix_hsv;
`endif

  // Coordinate tracking: advance on every valid pixel (dropped or not); SOF forces (0,0).
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    page_d     = page_q;
    sync_err_d = sync_err_q;
    pix_x      = x_q;
    pix_y      = y_q;
    pix_last   = 1'b0;
    if (i_pix_vld) begin
      if (i_pix_sof) begin
        pix_x = '0;
        pix_y = '0;
        x_d   = 8'd1;
        y_d   = '0;
        if (x_q != '0 || y_q != '0) sync_err_d = 1'b1;
      end else begin
        pix_last = (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d    = '0;
            page_d = ~page_q;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
    end
  end

  // FIFO entry assembly and occupancy update.
  always_comb begin
    pix_in.page = page_q;
    pix_in.y    = pix_y;
    pix_in.x    = pix_x;
    pix_in.hsv  = pix_hsv;
    pix_in.last = pix_last;
    cnt_d       = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: counters, pointers, flags; reset discards everything queued.
  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) begin
      x_q          <= '0;
      y_q          <= '0;
      page_q       <= 1'b0;
      sync_err_q   <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      page_q       <= page_d;
      sync_err_q   <= sync_err_d;
      ovf_q        <= ovf_q | (i_pix_vld & full);
      frame_done_q <= pop & head.last;
      cnt_q        <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Pixel storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge i_ppu_clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_in;
  end

  // The head entry is presented straight from storage, so it holds steady through stalls.
  assign o_vbuf_we    = ~empty;
  assign o_vbuf_addr  = empty ? 17'h0 : {head.page, head.y, head.x};
  assign o_vbuf_wdata = empty ? 8'h00 : {1'b0, head.hsv};
  assign o_pix_rdy    = ~full;
  assign o_wr_page    = page_q;
  assign o_frame_done = frame_done_q;
  assign o_ovf        = ovf_q;
  assign o_sync_err   = sync_err_q;

endmodule
